// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants for the shift-and-add multiplier.
// State encodings and default operand width.
package shift_add_mult_ctrl_pkg;

  localparam int SIZE_DEF = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_SHIFT = 2'b01;
  localparam logic [1:0] SEL_LOAD  = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

endpackage

// File: rtl/shift_add_mult_ctrl_mult_datapath.sv
// Shift-and-add datapath: shifting operand registers,
// ripple accumulator and product register.
module mult_datapath
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              shift,
  input  logic              acc_en,
  input  logic              p_ld,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              mplier_lsb,
  output logic [2*SIZE-1:0] p
);

  logic [2*SIZE-1:0] mcand, mcand_d;
  logic [SIZE-1:0]   mplier, mplier_d;
  logic [2*SIZE-1:0] acc, acc_d, sum;
  logic [1:0]        sel;

  assign sel = {ld, shift};
  assign sum = acc + mcand;
  assign mplier_lsb = mplier[0];

  always_comb begin
    mcand_d  = mcand;
    mplier_d = mplier;
    unique case (sel)
      SEL_HOLD: begin
        mcand_d  = mcand;
        mplier_d = mplier;
      end
      SEL_SHIFT: begin
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
      end
      SEL_LOAD: begin
        mcand_d  = {{SIZE{1'b0}}, a};
        mplier_d = b;
      end
      SEL_ZERO: begin
        mcand_d  = '0;
        mplier_d = '0;
      end
      default: ;
    endcase
  end

  // Final product includes the add made on the last RUN edge
  always_comb begin
    acc_d = acc;
    if (ld)
      acc_d = '0;
    else if (acc_en)
      acc_d = sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      p      <= '0;
    end else begin
      mcand  <= mcand_d;
      mplier <= mplier_d;
      acc    <= acc_d;
      if (p_ld)
        p <= acc_d;
    end
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: controller FSM with
// start/busy/done handshake driving mult_datapath.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  localparam int CW = $clog2(SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] p
);

  logic [1:0]    state, state_d;
  logic [CW-1:0] count;
  logic          accept, run, last;
  logic          mplier_lsb;

  assign run    = (state == S_RUN);
  assign accept = start & ((state == S_IDLE) | (state == S_DONE));
  assign last   = run & (count == CW'(SIZE - 1));
  assign busy   = run;
  assign done   = (state == S_DONE);

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == S_IDLE): state_d = accept ? S_RUN : S_IDLE;
      (state == S_RUN):  state_d = last ? S_DONE : S_RUN;
      (state == S_DONE): state_d = accept ? S_RUN : S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      if (accept)
        count <= '0;
      else if (run)
        count <= count + 1'b1;
    end
  end

  mult_datapath #(.SIZE(SIZE)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .ld         (accept),
    .shift      (run),
    .acc_en     (run & mplier_lsb),
    .p_ld       (last),
    .a          (a),
    .b          (b),
    .mplier_lsb (mplier_lsb),
    .p          (p)
  );

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl (SIZE=4 and SIZE=8).
// Hand-computed products and handshake timing.
module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [3:0]  a, b;
  logic [7:0]  a8, b8;
  logic        busy, done, busy8, done8;
  logic [7:0]  p;
  logic [15:0] p8;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.SIZE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  shift_add_mult_ctrl #(.SIZE(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .p     (p8)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One SIZE=4 product with nominal latency, start pulsed one cycle
  task automatic run4(input string tag, input logic [3:0] av,
                      input logic [3:0] bv, input logic [7:0] exp);
    start = 1'b1; a = av; b = bv;
    step();
    chk({tag, "_busy0"}, 16'(busy), 16'd1);
    start = 1'b0; a = 4'hx; b = 4'hx;
    step(); step(); step();
    chk({tag, "_busy3"}, 16'(busy), 16'd1);
    chk({tag, "_done3"}, 16'(done), 16'd0);
    step();
    chk({tag, "_done4"}, 16'(done), 16'd1);
    chk({tag, "_busy4"}, 16'(busy), 16'd0);
    chk({tag, "_p"}, 16'(p), 16'(exp));
    step();
    chk({tag, "_done5"}, 16'(done), 16'd0);
    a = 4'd0; b = 4'd0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_p", 16'(p), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // 3*5
    run4("t1", 4'd3, 4'd5, 8'd15);
    step(); step();
    chk("t1_hold", 16'(p), 16'd15);
    chk("t1_idle", 16'(busy), 16'd0);

    // 15*15, then 0*13 with the same latency
    run4("t2a", 4'd15, 4'd15, 8'hE1);
    run4("t2b", 4'd0, 4'd13, 8'd0);

    // start held high: back-to-back 2*7 then 6*6
    start = 1'b1; a = 4'd2; b = 4'd7;
    step();
    chk("t3_busy0", 16'(busy), 16'd1);
    a = 4'd6; b = 4'd6;
    step(); step(); step();
    chk("t3_busy3", 16'(busy), 16'd1);
    step();
    chk("t3_done4", 16'(done), 16'd1);
    chk("t3_nbusy4", 16'(busy), 16'd0);
    chk("t3_p14", 16'(p), 16'd14);
    step();
    chk("t3_busy5", 16'(busy), 16'd1);
    chk("t3_ndone5", 16'(done), 16'd0);
    chk("t3_phold", 16'(p), 16'd14);
    start = 1'b0;
    step(); step(); step();
    chk("t3_ndone8", 16'(done), 16'd0);
    step();
    chk("t3_done9", 16'(done), 16'd1);
    chk("t3_p36", 16'(p), 16'd36);
    step();
    chk("t3_idle", 16'(busy), 16'd0);

    // start re-asserted during RUN of 4*4 is ignored
    start = 1'b1; a = 4'd4; b = 4'd4;
    step();
    a = 4'd9; b = 4'd9;
    step(); step(); step();
    chk("t4_busy3", 16'(busy), 16'd1);
    step();
    chk("t4_done", 16'(done), 16'd1);
    chk("t4_p16", 16'(p), 16'd16);
    start = 1'b0;
    step();
    chk("t4_noacc", 16'(busy), 16'd0);
    chk("t4_phold", 16'(p), 16'd16);

    // async reset mid-RUN of 7*3
    start = 1'b1; a = 4'd7; b = 4'd3;
    step();
    start = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("t5_busy", 16'(busy), 16'd0);
    chk("t5_done", 16'(done), 16'd0);
    chk("t5_p", 16'(p), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    step(); step(); step(); step();
    chk("t5_nodone", 16'(done), 16'd0);
    run4("t5r", 4'd7, 4'd3, 8'd21);

    // SIZE=8: 200*255
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd255;
    step();
    chk("t6_busy0", 16'(busy8), 16'd1);
    start8 = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t6_done7", 16'(done8), 16'd0);
    chk("t6_busy7", 16'(busy8), 16'd1);
    step();
    chk("t6_done8", 16'(done8), 16'd1);
    chk("t6_p", p8, 16'd51000);
    step();
    chk("t6_done9", 16'(done8), 16'd0);
    chk("t6_phold", p8, 16'd51000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequential unsigned multiplier built from a controller FSM and a shift-and-add datapath: a multiplicand register shifting left, a multiplier register shifting right, and a 2*SIZE accumulator fed by a ripple adder.
- The FSM sequences the load, shift and accumulate strobes of the datapath registers.
- A start/busy/done handshake lets an upstream block request one product at a time.
- Fixed latency is kept regardless of operand values so downstream scheduling is static.

Parameters:
SIZE, 4, operand width in bits; product width is 2*SIZE.
CW, derived, counter width = ceil(log2(SIZE+1)); not overridable.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low; clears all state immediately when low.
start  input  1  request; sampled on rising clk edges.
a  input  SIZE  multiplicand, captured on the accepting edge.
b  input  SIZE  multiplier, captured on the accepting edge.
busy  output  1  high while state is RUN.
done  output  1  one-cycle pulse while state is DONE; p is valid at that time.
p  output  2*SIZE  product; holds its value until the next accepted start.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, busy=0, done=0, p=0, count=0, mcand=0, mplier=0. Applies at any time, including mid-RUN; the operation in progress is discarded and no done pulse occurs.
- States: IDLE, RUN, DONE. Encoding is 2 bits.
- IDLE:
  - If start=1 at an edge (the "accept"): mcand <= zero-extended a (2*SIZE bits), mplier <= b, acc <= 0, count <= 0, next state RUN.
  - Otherwise hold.
- RUN, each edge:
  - If mplier[0]=1, acc <= acc + mcand; otherwise acc holds.
  - mcand <= mcand << 1 with zero fill; mplier <= mplier >> 1 with zero fill; count <= count+1.
  - When count==SIZE-1 at the edge, next state DONE and p <= the final acc value, including this edge's add.
  - start is ignored in RUN.
- DONE, one cycle:
  - done=1.
  - If start=1 at the edge, accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency:
  - Accept at edge E0; RUN occupies edges E1..E(SIZE); state is DONE from E(SIZE) to E(SIZE+1).
  - busy=1 from E0 to E(SIZE). done=1 from E(SIZE) to E(SIZE+1).
  - Back-to-back throughput is one product per SIZE+1 cycles.
- Arithmetic: unsigned only; the 2*SIZE accumulator cannot overflow, since max is (2^SIZE-1)^2. The adder carry-out is ignored.
- Fixed latency: there is no early exit when mplier reaches 0.
- busy and done are decoded from registered state only, so both are glitch-free. They are never high together.
- Inputs a and b need only be stable at the accepting edge.

Decomposition:
- Shared include file: state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and the default SIZE.
- One natural sub-module, mult_datapath, parameterised by SIZE. It contains:
  - the mcand left-shift register and the mplier right-shift register, each a 4-to-1 mux (hold/shift/load/zero) feeding a register;
  - the 2*SIZE accumulator and adder.
  - It takes strobes ld, shift and acc_en from the controller FSM.
- The controller holds the state register and count.

Test Plan:
1. SIZE=4, a=3, b=5, start pulsed one cycle -> busy high for 4 cycles; done pulses 4 cycles after accept; p=15; p stays 15 while idle.
2. a=15, b=15 -> p=225 (8'hE1), no overflow; then a=0, b=13 -> p=0 with identical latency (no early exit).
3. start held high continuously with a=2, b=7, then a=6, b=6 -> done pulses every 5 cycles; p=14, then p=36; busy low only during DONE cycles.
4. start re-asserted with a=9, b=9 during RUN of 4*4 -> ignored; p=16; the second request is accepted only in DONE or IDLE.
5. reset driven low at a mid-cycle instant during RUN of 7*3 -> busy, done and p go to 0 immediately without a clock edge. After release, a fresh 7*3 gives p=21 with nominal latency.
6. SIZE=8 instance, a=200, b=255 -> p=51000 after 8 RUN cycles; done is a single-cycle pulse.
